// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one registered ALU between NREQ requesters,
// holding operands through the ALU latency and returning the result to the winner.
module alu_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 4,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [DW-1:0]       resp_result,
  output logic                resp_flag,
  output logic [OPW-1:0]      alu_op,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_flag,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [OPW-1:0]      alu_op_q, alu_op_d;
  logic [DW-1:0]       alu_a_q, alu_a_d;
  logic [DW-1:0]       alu_b_q, alu_b_d;
  logic [NREQ-1:0]     resp_valid_q, resp_valid_d;
  logic [DW-1:0]       resp_result_q, resp_result_d;
  logic                resp_flag_q, resp_flag_d;

  logic [PW-1:0]       win;
  logic                win_found;
  logic [PW:0]         idx;
  logic [NREQ-1:0]     grant_onehot;
  logic                accept;

  // Scan from the highest rotation offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (req_valid[idx[PW-1:0]]) begin
        win       = idx[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign req_ready[gi]    = rst_n & (state_q == IDLE) & win_found & (win == PW'(gi));
      assign grant_onehot[gi] = (grant_q == PW'(gi));
    end
  endgenerate

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    wait_cnt_d    = wait_cnt_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_flag_d   = resp_flag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_op_d   = req_op[int'(win)*OPW +: OPW];
          alu_a_d    = req_a[int'(win)*DW +: DW];
          alu_b_d    = req_b[int'(win)*DW +: DW];
          grant_d    = win;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // wait_cnt counts edges spent in WAIT; the ALU output for the held operands
        // is settled once ALU_LAT of them have passed.
        if (wait_cnt_q == CW'(ALU_LAT)) begin
          resp_result_d = alu_result;
          resp_flag_d   = alu_flag;
          resp_valid_d  = grant_onehot;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready[grant_q]) begin
          resp_valid_d = '0;
          rr_ptr_d     = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      wait_cnt_q    <= '0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      wait_cnt_q    <= wait_cnt_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flag_q   <= resp_flag_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flag   = resp_flag_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model (owner, age since accept, round-robin pointer).
module tb_alu_req_arbiter;
  localparam int N = 2, DW = 4, OPW = 3, LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [N*OPW-1:0]  req_op;
  logic [N*DW-1:0]   req_a, req_b;
  logic [DW-1:0]     resp_result, alu_a, alu_b, alu_result;
  logic              resp_flag, alu_flag, busy;
  logic [OPW-1:0]    alu_op;

  alu_req_arbiter #(.NREQ(N), .DW(DW), .OPW(OPW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_result(resp_result), .resp_flag(resp_flag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_flag(alu_flag), .busy(busy));

  // Second instance with a 3-cycle ALU.
  logic [N-1:0]      v3, rdy3, rv3, rr3;
  logic [N*OPW-1:0]  op3;
  logic [N*DW-1:0]   a3, b3;
  logic [DW-1:0]     res3, aa3, ab3, ar3;
  logic              flg3, af3, busy3;
  logic [OPW-1:0]    aop3;
  logic [4:0]        p1, p2, p3;

  alu_req_arbiter #(.NREQ(N), .DW(DW), .OPW(OPW), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
    .req_op(op3), .req_a(a3), .req_b(b3), .resp_valid(rv3),
    .resp_ready(rr3), .resp_result(res3), .resp_flag(flg3),
    .alu_op(aop3), .alu_a(aa3), .alu_b(ab3), .alu_result(ar3),
    .alu_flag(af3), .busy(busy3));

  // Reference ALU: {flag, result}; flag is signed overflow for add/sub.
  function automatic logic [4:0] alu_fn(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    logic [3:0] s;
    logic       f;
    f = 1'b0;
    case (op)
      3'd0: begin s = a + b; f = (a[3] == b[3]) && (s[3] != a[3]); end
      3'd1: begin s = a - b; f = (a[3] != b[3]) && (s[3] != a[3]); end
      3'd2: s = a & b;
      3'd3: s = a | b;
      3'd4: s = a ^ b;
      default: s = a;
    endcase
    return {f, s};
  endfunction

  always @(posedge clk) {alu_flag, alu_result} <= alu_fn(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    p1 <= alu_fn(aop3, aa3, ab3);
    p2 <= p1;
    p3 <= p2;
  end
  assign {af3, ar3} = p3;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: owner = requester being served (-1 none), age = edges since its accept.
  int         m_owner, m_age, m_ptr;
  logic [2:0] m_op;
  logic [3:0] m_a, m_b, m_res;
  logic       m_flag;

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ptr = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_flag = 1'b0;
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int w;
    w = winner();
    if (!rst_n || m_owner >= 0 || w < 0) return '0;
    return N'(1) << w;
  endfunction

  task automatic compare();
    logic [N-1:0] ev;
    ev = (m_owner >= 0 && m_age > LAT) ? (N'(1) << m_owner) : N'(0);
    chk("req_ready",   32'(req_ready),   32'(m_ready()));
    chk("resp_valid",  32'(resp_valid),  32'(ev));
    chk("resp_result", 32'(resp_result), 32'(m_res));
    chk("resp_flag",   32'(resp_flag),   32'(m_flag));
    chk("alu_op",      32'(alu_op),      32'(m_op));
    chk("alu_a",       32'(alu_a),       32'(m_a));
    chk("alu_b",       32'(alu_b),       32'(m_b));
    chk("busy",        32'(busy),        32'(m_owner >= 0));
  endtask

  task automatic model_step();
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      w = winner();
      if (w >= 0) begin
        m_owner = w; m_age = 0;
        m_op = req_op[w*OPW +: OPW]; m_a = req_a[w*DW +: DW]; m_b = req_b[w*DW +: DW];
      end
    end else if (m_age <= LAT) begin
      m_age++;
      if (m_age == LAT + 1) {m_flag, m_res} = alu_fn(m_op, m_a, m_b);
    end else if (resp_ready[m_owner]) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  // Called right after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1;
    if (!rst_n) model_reset();
    compare();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    req_valid[i] = v;
    req_op[i*OPW +: OPW] = op;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = '0;
    v3 = '0; op3 = '0; a3 = '0; b3 = '0; rr3 = '0;
    model_reset();
    @(negedge clk);
    tick();
    chk("reset busy", 32'(busy), 32'(0));
    rst_n = 1'b1;

    // T1: single request from requester 0.
    set_req(0, 1'b1, 3'd0, 4'd3, 4'd5);
    #1 chk("T1 ready", 32'(req_ready), 32'(2'b01));
    tick();
    #1 chk("T1 busy", 32'(busy), 32'(1));
    tick();
    #1 chk("T1 early resp", 32'(resp_valid), 32'(0));
    tick();
    resp_ready = 2'b01;
    #1 chk("T1 resp_valid", 32'(resp_valid), 32'(2'b01));
    chk("T1 result", 32'(resp_result), 32'(8));
    chk("T1 flag", 32'(resp_flag), 32'(1));
    tick();
    set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    resp_ready = 2'b00;
    #1 chk("T1 busy after", 32'(busy), 32'(0));
    tick();

    // T2: contention right after reset, then T3/T4 backpressure on the third round.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'd0, 4'd1, 4'd2);
    set_req(1, 1'b1, 3'd1, 4'd6, 4'd2);
    resp_ready = 2'b11;
    #1 chk("T2 grant 1st", 32'(req_ready), 32'(2'b01));
    tick();
    repeat (LAT + 2) tick();
    #1 chk("T2 grant 2nd", 32'(req_ready), 32'(2'b10));
    tick();
    repeat (LAT + 2) tick();
    #1 chk("T2 grant 3rd", 32'(req_ready), 32'(2'b01));
    tick();
    resp_ready = 2'b00;
    repeat (LAT + 1) tick();
    for (int k = 0; k < 5; k++) begin
      resp_ready = (k < 2) ? 2'b00 : 2'b10;
      #1 chk("T3 hold valid", 32'(resp_valid), 32'(2'b01));
      chk("T3 no ready", 32'(req_ready), 32'(0));
      chk("T3 hold result", 32'(resp_result), 32'(3));
      tick();
    end
    resp_ready = 2'b01;
    tick();
    set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    resp_ready = 2'b11;
    #1 chk("T3 req1 next", 32'(req_ready), 32'(2'b10));
    tick();
    repeat (LAT + 2) tick();
    set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
    resp_ready = 2'b00;
    tick();

    // T5: reset while waiting on the ALU.
    set_req(0, 1'b1, 3'd0, 4'd1, 4'd1);
    tick();
    #2 rst_n = 1'b0;
    #1 chk("T5 busy", 32'(busy), 32'(0));
    chk("T5 alu_a", 32'(alu_a), 32'(0));
    chk("T5 ready", 32'(req_ready), 32'(0));
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("T5 no resp", 32'(resp_valid), 32'(0));
      tick();
    end
    set_req(1, 1'b1, 3'd0, 4'd7, 4'd1);
    resp_ready = 2'b10;
    #1 chk("T5 ready", 32'(req_ready), 32'(2'b10));
    tick();
    repeat (LAT + 1) tick();
    #1 chk("T5 resp_valid", 32'(resp_valid), 32'(2'b10));
    chk("T5 result", 32'(resp_result), 32'(8));
    chk("T5 flag", 32'(resp_flag), 32'(1));
    tick();
    set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
    resp_ready = 2'b00;
    tick();

    // Randomized traffic; a granted requester holds its request until its response.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (m_owner != i)
          set_req(i, 1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                  4'($urandom), 4'($urandom));
      resp_ready = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 6; c++) begin
      for (int i = 0; i < N; i++)
        if (m_owner != i) set_req(i, 1'b0, 3'd0, 4'd0, 4'd0);
      resp_ready = 2'b11;
      tick();
    end
    resp_ready = 2'b00;

    // T6: ALU_LAT=3 instance.
    v3 = 2'b01; op3[0 +: OPW] = 3'd0; a3[0 +: DW] = 4'd2; b3[0 +: DW] = 4'd3;
    #1 chk("T6 ready", 32'(rdy3), 32'(2'b01));
    tick();
    for (int k = 1; k <= 4; k++) begin
      #1 chk("T6 alu_a", 32'(aa3), 32'(2));
      chk("T6 alu_b", 32'(ab3), 32'(3));
      chk("T6 alu_op", 32'(aop3), 32'(0));
      chk("T6 no resp", 32'(rv3), 32'(0));
      tick();
    end
    rr3 = 2'b01;
    #1 chk("T6 resp_valid", 32'(rv3), 32'(2'b01));
    chk("T6 result", 32'(res3), 32'(5));
    chk("T6 flag", 32'(flg3), 32'(0));
    tick();
    v3 = 2'b00; rr3 = 2'b00;
    #1 chk("T6 busy after", 32'(busy3), 32'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
